// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges never-stalled ALU results with FIFO-buffered load
// results onto the register bank's single write port, exporting a pending-load mask.
module wb_write_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    AluValid,
    input  logic [ADDR_W-1:0]       AluReg,
    input  logic [DATA_W-1:0]       AluData,
    input  logic                    LoadValid,
    input  logic [ADDR_W-1:0]       LoadReg,
    input  logic [DATA_W-1:0]       LoadData,
    output logic                    LoadReady,
    output logic [ADDR_W-1:0]       WriteRegister,
    output logic [DATA_W-1:0]       WriteData,
    output logic                    RegWrite,
    output logic [(2**ADDR_W)-1:0]  Pending,
    output logic [$clog2(DEPTH):0]  FifoCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  live_q, live_d;
    logic [ADDR_W-1:0] reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              reg_write_q, reg_write_d;
    logic [NREG-1:0]   pending;

    logic alu_issue, pop, push;

    assign LoadReady = rst_n & (count_q != FULL_CNT);
    assign alu_issue = AluValid && (AluReg != '0);
    assign pop       = !alu_issue && (count_q != '0);
    // Loads to register 0 complete the handshake but never occupy a slot.
    assign push      = LoadValid && LoadReady && (LoadReg != '0);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        live_d      = live_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        reg_write_d = 1'b0;

        if (alu_issue) begin
            reg_write_d = 1'b1;
            wr_reg_d    = AluReg;
            wr_data_d   = AluData;
            // The ALU result is younger than every queued load to the same register.
            for (int k = 0; k < DEPTH; k++) begin
                if (reg_mem[k] == AluReg) live_d[k] = 1'b0;
            end
        end else if (pop) begin
            reg_write_d = live_q[rd_ptr_q];
            if (live_q[rd_ptr_q]) begin
                wr_reg_d  = reg_mem[rd_ptr_q];
                wr_data_d = data_mem[rd_ptr_q];
            end
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        // Applied after the kill so a same-cycle load to the killed register stays live.
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (live_q[k]) pending[reg_mem[k]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            live_q      <= '0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            live_q      <= live_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            reg_write_q <= reg_write_d;
        end
    end

    // NOTE: entry storage is not reset; live bits and the count decide what is ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr_q]  <= LoadReg;
            data_mem[wr_ptr_q] <= LoadData;
        end
    end

    assign WriteRegister = wr_reg_q;
    assign WriteData     = wr_data_q;
    assign RegWrite      = reg_write_q;
    assign Pending       = pending;
    assign FifoCount     = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: queue-based reference model compared every
// cycle, plus hand-computed expectations at the interesting points.
module tb_wb_write_arbiter;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              AluValid, LoadValid;
    logic [ADDR_W-1:0] AluReg, LoadReg;
    logic [DATA_W-1:0] AluData, LoadData;
    logic              LoadReady, RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [31:0]       Pending;
    logic [2:0]        FifoCount;

    int checks   = 0;
    int failures = 0;

    wb_write_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
        .LoadValid(LoadValid), .LoadReg(LoadReg), .LoadData(LoadData),
        .LoadReady(LoadReady), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .RegWrite(RegWrite), .Pending(Pending), .FifoCount(FifoCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO as a queue of {live, reg, data}.
    typedef struct {
        logic              live;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    logic              model_ok = 1'b0;
    logic              exp_rw;
    logic [ADDR_W-1:0] exp_wr;
    logic [DATA_W-1:0] exp_wd;

    always @(posedge clk) begin
        ent_t e;
        logic ready;
        if (!rst_n) begin
            q.delete();
            exp_rw   = 1'b0;
            exp_wr   = '0;
            exp_wd   = '0;
            model_ok = 1'b1;
        end else begin
            ready = (q.size() < DEPTH);
            if (AluValid && AluReg != 0) begin
                foreach (q[i]) if (q[i].r == AluReg) q[i].live = 1'b0;
                exp_rw = 1'b1;
                exp_wr = AluReg;
                exp_wd = AluData;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                exp_rw = e.live;
                if (e.live) begin
                    exp_wr = e.r;
                    exp_wd = e.d;
                end
            end else begin
                exp_rw = 1'b0;
            end
            if (LoadValid && ready && LoadReg != 0) begin
                e.live = 1'b1;
                e.r    = LoadReg;
                e.d    = LoadData;
                q.push_back(e);
            end
        end
    end

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (q[i]) if (q[i].live) p[q[i].r] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Observed bank contents and watch flags, built from the DUT write port.
    logic [DATA_W-1:0] bank  [32];
    logic              wrote [32];
    logic              seen55 = 1'b0;

    initial foreach (wrote[i]) begin
        wrote[i] = 1'b0;
        bank[i]  = '0;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            if (RegWrite === 1'b1) begin
                bank[WriteRegister]  = WriteData;
                wrote[WriteRegister] = 1'b1;
                if (WriteData == 32'h55) seen55 = 1'b1;
            end
            check("cyc_RegWrite", RegWrite, exp_rw);
            if (exp_rw) begin
                check("cyc_WriteRegister", WriteRegister, exp_wr);
                check("cyc_WriteData", WriteData, exp_wd);
            end
            check("cyc_FifoCount", FifoCount, q.size());
            check("cyc_Pending", Pending, model_pending());
            check("cyc_LoadReady", LoadReady, rst_n && (q.size() < DEPTH));
        end
    end

    task automatic set_in(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        AluValid = av; AluReg = ar; AluData = ad;
        LoadValid = lv; LoadReg = lr; LoadData = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        set_in(av, ar, ad, lv, lr, ld);
        tick();
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) begin
            set_in(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
            tick();
        end
        check("rst_RegWrite", RegWrite, 1'b0);
        check("rst_LoadReady", LoadReady, 1'b0);
        check("rst_FifoCount", FifoCount, 3'd0);
        check("rst_Pending", Pending, 32'h0);

        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_LoadReady", LoadReady, 1'b1);
        idle();
        check("rel_no_write", RegWrite, 1'b0);

        // ALU only
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        check("alu_RegWrite", RegWrite, 1'b1);
        check("alu_WriteRegister", WriteRegister, 5'd5);
        check("alu_WriteData", WriteData, 32'hDEADBEEF);
        cyc(1'b1, 5'd0, 32'h123, 1'b0, 5'd0, 32'h0);
        check("alu_r0_ignored", RegWrite, 1'b0);

        // Load drain
        cyc(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h11);
        cyc(1'b1, 5'd2, 32'h200, 1'b1, 5'd4, 32'h22);
        check("drain_count", FifoCount, 3'd2);
        check("drain_pending", Pending, 32'h18);
        check("drain_alu_reg", WriteRegister, 5'd2);
        idle();
        check("drain1_reg", WriteRegister, 5'd3);
        check("drain1_data", WriteData, 32'h11);
        check("drain1_pending", Pending, 32'h10);
        idle();
        check("drain2_reg", WriteRegister, 5'd4);
        check("drain2_data", WriteData, 32'h22);
        check("drain2_pending", Pending, 32'h0);

        // Full
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 5'd1, 32'h101 + i, 1'b1, 5'(8 + i), 32'h31 + i);
        check("full_count", FifoCount, 3'd4);
        set_in(1'b1, 5'd1, 32'h105, 1'b1, 5'd12, 32'h55);
        #1;
        check("full_not_ready", LoadReady, 1'b0);
        tick();
        check("full_count_hold", FifoCount, 3'd4);
        idle();
        check("free_reg", WriteRegister, 5'd8);
        check("free_data", WriteData, 32'h31);
        check("free_ready", LoadReady, 1'b1);
        repeat (3) idle();
        check("full_drained", FifoCount, 3'd0);

        // Kill
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAA);
        check("kill_pend_set", Pending, 32'h80);
        cyc(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'h0);
        check("kill_pend_clr", Pending, 32'h0);
        check("kill_count", FifoCount, 3'd1);
        idle();
        check("kill_dead_pop", RegWrite, 1'b0);
        check("kill_bank7", bank[7], 32'hBB);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hA7);
        cyc(1'b1, 5'd7, 32'hB2, 1'b1, 5'd7, 32'hCC);
        check("same_count", FifoCount, 3'd2);
        check("same_pending", Pending, 32'h80);
        idle();
        check("same_dead_pop", RegWrite, 1'b0);
        idle();
        check("same_live_write", RegWrite, 1'b1);
        check("same_live_data", WriteData, 32'hCC);

        // Load to $0
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
        #1;
        check("r0_ready", LoadReady, 1'b1);
        tick();
        check("r0_count", FifoCount, 3'd0);
        idle();
        check("r0_no_write", RegWrite, 1'b0);

        // Reset mid-drain
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'd1, 32'h300 + i, 1'b1, 5'(13 + i), 32'hD1 + i);
        check("mid_count", FifoCount, 3'd3);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_count", FifoCount, 3'd0);
        check("mid_rst_pending", Pending, 32'h0);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("mid_no_write", RegWrite, 1'b0);
        end

        check("never_wrote_r0", wrote[0], 1'b0);
        check("never_wrote_r13", wrote[13], 1'b0);
        check("never_wrote_r15", wrote[15], 1'b0);
        check("rejected_data_absent", seen55, 1'b0);
        check("final_bank7", bank[7], 32'hCC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
